condicionador_botoes: RTL

Input conditioner that sits directly upstream of the game datapath's botoes/jogada inputs. It synchronizes the raw push-buttons, debounces press and release, and emits exactly one single-cycle jogada pulse per valid press. Each valid press is accompanied by a registered one-hot code and binary index. Multi-button presses are rejected with a separate pulse, so the game FSM only ever sees clean, one-hot, one-cycle plays.

---
 rtl/condicionador_botoes.sv | 121 ++++++++++++
 1 files changed

// File: rtl/condicionador_botoes.sv
// condicionador_botoes: synchronizes, debounces and validates push-buttons into clean one-hot single-cycle plays
module condicionador_botoes #(
    parameter int N_BOTOES        = 4,
    parameter int W_INDICE        = 2,
    parameter int DEBOUNCE_CICLOS = 3,
    parameter int W_CONT          = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                habilita,
    input  logic [N_BOTOES-1:0] botoes,
    output logic                jogada,
    output logic [N_BOTOES-1:0] jogada_codigo,
    output logic [W_INDICE-1:0] jogada_indice,
    output logic                multipla,
    output logic                ocupado,
    output logic [3:0]          db_estado
);

    typedef enum logic [1:0] {
        ESPERA  = 2'd0,
        FILTRA  = 2'd1,
        EMITE   = 2'd2,
        SOLTURA = 2'd3
    } estado_t;

    localparam logic [W_CONT-1:0] LIMITE = W_CONT'(DEBOUNCE_CICLOS);

    estado_t             estado;
    logic [N_BOTOES-1:0] sync1;
    logic [N_BOTOES-1:0] s;
    logic [N_BOTOES-1:0] cand;
    logic [W_CONT-1:0]   cnt;
    logic                cand_um;
    logic [W_INDICE-1:0] cand_idx;

    // candidate is a valid play only when exactly one bit is set; index is its bit position
    always_comb begin
        cand_um  = (cand != '0) && ((cand & (cand - N_BOTOES'(1))) == '0);
        cand_idx = '0;
        for (int i = 0; i < N_BOTOES; i++)
            if (cand[i]) cand_idx = W_INDICE'(i);
    end

    // two-flop synchronizer, debounce FSM and registered Moore outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1         <= '0;
            s             <= '0;
            cand          <= '0;
            cnt           <= '0;
            estado        <= ESPERA;
            jogada        <= 1'b0;
            multipla      <= 1'b0;
            jogada_codigo <= '0;
            jogada_indice <= '0;
            ocupado       <= 1'b0;
            db_estado     <= 4'd0;
        end else begin
            sync1 <= botoes;
            s     <= sync1;
            case (estado)
                ESPERA: begin
                    if (habilita && s != '0) begin
                        cand      <= s;
                        cnt       <= W_CONT'(1);
                        estado    <= FILTRA;
                        ocupado   <= 1'b1;
                        db_estado <= 4'd1;
                    end
                end
                FILTRA: begin
                    if (s != cand) begin
                        estado    <= ESPERA;
                        ocupado   <= 1'b0;
                        db_estado <= 4'd0;
                    end else if (!habilita) begin
                        estado    <= SOLTURA;
                        db_estado <= 4'd3;
                    end else if (cnt == LIMITE) begin
                        estado    <= EMITE;
                        db_estado <= 4'd2;
                        if (cand_um) begin
                            jogada        <= 1'b1;
                            jogada_codigo <= cand;
                            jogada_indice <= cand_idx;
                        end else begin
                            multipla <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + W_CONT'(1);
                    end
                end
                EMITE: begin
                    jogada    <= 1'b0;
                    multipla  <= 1'b0;
                    cnt       <= '0;
                    estado    <= SOLTURA;
                    db_estado <= 4'd3;
                end
                SOLTURA: begin
                    if (s != '0) begin
                        cnt <= '0;
                    end else if (cnt == LIMITE) begin
                        estado    <= ESPERA;
                        ocupado   <= 1'b0;
                        db_estado <= 4'd0;
                    end else begin
                        cnt <= cnt + W_CONT'(1);
                    end
                end
                default: begin
                    estado    <= ESPERA;
                    ocupado   <= 1'b0;
                    db_estado <= 4'd0;
                end
            endcase
        end
    end

endmodule
